sensor_sync_gate: RTL
=====================

// Module: sensor_sync_gate
// PURPOSE
//   Parametrised track-sensor synchroniser/gate for the train controller. Takes NUM_SENSORS asynchronous
//   track-sensor lines and runs each through a 2-flop synchroniser and a debounce filter. On each Enable
//   request it evaluates one programmable rule, chosen by Selector, against the debounced sensor vector
//   and returns the registered go/no-go output Y with a Valid strobe. It sits between the sensor pins and
//   the route/segment controller FSM.
// PARAMETERS
//   NUM_SENSORS      6   number of sensor inputs (1..32)
//   NUM_RULES        16  rule-table entries; Selector values >= NUM_RULES are illegal
//   SEL_W            5   width of Selector and RuleAddr
//   DEBOUNCE_CYCLES  4   cycles a synced level must persist before Clean follows it (>=1)
// PORTS
//   Clk       in   1            system clock, rising edge
//   Reset     in   1            asynchronous, active-high reset
//   Sensors   in   NUM_SENSORS  raw asynchronous sensor lines, 1 = train present
//   Selector  in   SEL_W        rule index; sampled when a request is accepted
//   Enable    in   1            evaluation request (level); one evaluation per high phase
//   RuleWe    in   1            rule-table write strobe
//   RuleAddr  in   SEL_W        rule-table write address
//   RuleData  in   2+NUM_SENSORS {mode[1:0], mask[NUM_SENSORS-1:0]}
//   Y         out  1            registered evaluation result; held until the next evaluation
//   Valid     out  1            1-cycle pulse when Y is updated
//   SelErr    out  1            registered; 1 if the last evaluation used an illegal Selector
//   Busy      out  1            1 while in EVAL or DONE
//   Clean     out  NUM_SENSORS  debounced sensor vector
// BEHAVIOUR
//   Reset (async, any time): sync flops, Clean, and debounce counters -> 0; FSM -> IDLE; Y=0, Valid=0,
//     SelErr=0, Busy=0; rule table -> pkg DEFAULT_RULES (mask truncated/zero-extended to NUM_SENSORS).
//   Sync: two flops per sensor, no reset-release glitch handling beyond reset value 0.
//   Debounce (per sensor): if synced==Clean, cnt<=0. Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1
//     while still differing, Clean<=synced and cnt<=0. Pin-to-Clean latency = 2+DEBOUNCE_CYCLES cycles.
//     A differing pulse shorter than DEBOUNCE_CYCLES never reaches Clean.
//   Rule modes (m = mask, c = Clean): 0 ANY = |(c&m); 1 NONE = ~|(c&m); 2 ALL = &(c|~m); 3 ONE = 1.
//     ANY with m=0 gives constant 0.
//   FSM IDLE -> EVAL: Enable==1 in IDLE; latch Selector into sel_q.
//     EVAL -> DONE: compute the rule for sel_q on the current Clean; register Y; pulse Valid.
//       If sel_q>=NUM_RULES: Y=0, SelErr=1. Otherwise SelErr=0.
//     DONE -> IDLE: Enable==0. Holding Enable high gives exactly one evaluation.
//   Latency: Enable rises at edge k -> Y/Valid visible after edge k+2.
//   Rule write: RuleWe=1 updates the entry at the next edge; RuleAddr>=NUM_RULES is ignored.
//     A write to the entry read in the same EVAL cycle is not seen by that evaluation (old value used).
//   Enable toggling during EVAL is ignored; Enable low for a single cycle in DONE returns to IDLE.
// CONFIGURATION
//   SYNC_STICKY_EN defined: per-sensor sticky register, set on each Clean 0->1 edge and cleared in the
//     EVAL cycle. EVAL uses (Clean | sticky), so a train that passed between evaluations is still seen.
//     A set and a clear in the same cycle resolve to set (the edge is kept for the next evaluation).
//   SYNC_STICKY_EN undefined: no sticky logic; EVAL uses Clean only.
// STRUCTURE
//   Package sensor_sync_pkg: rule_mode_t enum {MODE_ANY, MODE_NONE, MODE_ALL, MODE_ONE},
//     MAX_SENSORS=32, DEFAULT_RULES[16] {mode,mask} table, FSM state enum {S_IDLE,S_EVAL,S_DONE}.
//   Sub-module sensor_debounce (one sensor: 2-flop sync + counter + Clean), instantiated NUM_SENSORS
//     times by generate. Rule table, sticky logic and FSM live in the top level.
// TESTING
//   Reset, then Sensors=6'b000001 held 8 cycles, DEBOUNCE_CYCLES=4 -> Clean[0] rises exactly 6 cycles after the pin.
//   3-cycle glitch on Sensors[2] -> Clean stays 0; SelErr/Y unchanged.
//   Write RuleAddr=3, RuleData={MODE_NONE,6'b001111}; Clean=6'b010000; Enable pulse with Selector=3
//     -> Valid after 2 edges, Y=1. Repeat with Clean=6'b000100 -> Y=0.
//   Selector=20 (>=NUM_RULES) -> Y=0, SelErr=1, Valid pulses once; Enable held 10 cycles -> one Valid only.
//   SYNC_STICKY_EN: Clean[5] pulses 0->1->0 while IDLE; then Selector with {MODE_ANY,6'b100000} -> Y=1;
//     second evaluation -> Y=0.
//   Assert Reset during EVAL -> Y=0, Valid=0, Busy=0 immediately; rule table back to DEFAULT_RULES.

Source files
------------

// File: rtl/sensor_sync_pkg.sv
// Shared types, constants and helpers for the track-sensor synchroniser/gate.
//   rule_mode_t   : evaluation mode stored in each rule-table entry
//   state_t       : request FSM states
//   rule_t        : {mode, mask} payload at full MAX_SENSORS width
//   DEFAULT_RULES : rule-table contents after reset
package sensor_sync_pkg;

    localparam int unsigned MAX_SENSORS       = 32;
    localparam int unsigned MODE_W            = 2;
    localparam int unsigned NUM_DEFAULT_RULES = 16;
    localparam int unsigned DR_IDX_W          = 4;

    typedef enum logic [1:0] {
        MODE_ANY  = 2'd0,
        MODE_NONE = 2'd1,
        MODE_ALL  = 2'd2,
        MODE_ONE  = 2'd3
    } rule_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        rule_mode_t             mode;
        logic [MAX_SENSORS-1:0] mask;
    } rule_t;

    // Bit n of a mask refers to sensor n; masks are truncated to the instance width.
    localparam rule_t DEFAULT_RULES [NUM_DEFAULT_RULES] = '{
        '{MODE_ANY,  32'h0000_003F},
        '{MODE_NONE, 32'h0000_003F},
        '{MODE_ALL,  32'h0000_003F},
        '{MODE_ONE,  32'h0000_0000},
        '{MODE_ANY,  32'h0000_0001},
        '{MODE_ANY,  32'h0000_0002},
        '{MODE_ANY,  32'h0000_0004},
        '{MODE_ANY,  32'h0000_0008},
        '{MODE_ANY,  32'h0000_0010},
        '{MODE_ANY,  32'h0000_0020},
        '{MODE_NONE, 32'h0000_0003},
        '{MODE_NONE, 32'h0000_000C},
        '{MODE_NONE, 32'h0000_0030},
        '{MODE_ALL,  32'h0000_0003},
        '{MODE_ALL,  32'h0000_0030},
        '{MODE_ANY,  32'h0000_0000}
    };

    // Entries past the default table reset to ANY with an empty mask (constant 0).
    function automatic rule_mode_t default_mode(int unsigned idx);
        if (idx < NUM_DEFAULT_RULES) return DEFAULT_RULES[DR_IDX_W'(idx)].mode;
        return MODE_ANY;
    endfunction

    function automatic logic [MAX_SENSORS-1:0] default_mask(int unsigned idx);
        if (idx < NUM_DEFAULT_RULES) return DEFAULT_RULES[DR_IDX_W'(idx)].mask;
        return '0;
    endfunction

    // Unused upper bits of c and m must be zero so ALL/ANY ignore them.
    function automatic logic eval_rule(rule_mode_t mode,
                                       logic [MAX_SENSORS-1:0] c,
                                       logic [MAX_SENSORS-1:0] m);
        logic r;
        r = 1'b1;
        case (mode)
            MODE_ANY:  r = |(c & m);
            MODE_NONE: r = ~|(c & m);
            MODE_ALL:  r = &(c | ~m);
            MODE_ONE:  r = 1'b1;
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sensor_sync_gate_debounce.sv
// One sensor lane: 2-flop synchroniser followed by a persistence filter.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   raw   : asynchronous sensor pin
//   clean : debounced level; follows the synced level after it has differed
//           for DEBOUNCE_CYCLES consecutive cycles (pin-to-clean 2+DEBOUNCE_CYCLES)
module sensor_debounce
    import sensor_sync_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;

    // Metastability synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // Count consecutive differing cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (sync1 == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            clean <= sync1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sensor_sync_gate.sv
// Track-sensor synchroniser/gate: debounces NUM_SENSORS pins and, once per
// Enable high phase, evaluates the rule selected by Selector against them.
//   Clk, Reset          : clock, asynchronous active-high reset
//   Sensors             : raw asynchronous sensor lines (1 = train present)
//   Selector, Enable    : rule index and evaluation request (level)
//   RuleWe/Addr/Data    : rule-table write port, data = {mode[1:0], mask}
//   Y, Valid, SelErr    : registered result, 1-cycle update strobe, illegal-selector flag
//   Busy                : high while in EVAL or DONE
//   Clean               : debounced sensor vector
// Optional build macro SYNC_STICKY_EN: evaluations also see sensors whose
// Clean rose since the previous evaluation (sticky capture).
module sensor_sync_gate
    import sensor_sync_pkg::*;
#(
    parameter int unsigned NUM_SENSORS     = 6,
    parameter int unsigned NUM_RULES       = 16,
    parameter int unsigned SEL_W           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_SENSORS-1:0]      Sensors,
    input  logic [SEL_W-1:0]            Selector,
    input  logic                        Enable,
    input  logic                        RuleWe,
    input  logic [SEL_W-1:0]            RuleAddr,
    input  logic [MODE_W+NUM_SENSORS-1:0] RuleData,
    output logic                        Y,
    output logic                        Valid,
    output logic                        SelErr,
    output logic                        Busy,
    output logic [NUM_SENSORS-1:0]      Clean
);

    localparam int unsigned RULE_W = MODE_W + NUM_SENSORS;
    localparam int unsigned IDX_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

    logic [RULE_W-1:0]      rules [NUM_RULES];
    logic [NUM_SENSORS-1:0] eval_vec;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q;
    logic                   latch_sel;
    logic                   y_q, y_d;
    logic                   valid_q, valid_d;
    logic                   selerr_q, selerr_d;
    logic                   busy_q, busy_d;

    logic                   sel_legal;
    logic [RULE_W-1:0]      rule_cur;
    logic                   rule_hit;

    // Per-sensor synchroniser + debounce lanes.
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (Clk),
            .rst   (Reset),
            .raw   (Sensors[i]),
            .clean (Clean[i])
        );
    end

`ifdef SYNC_STICKY_EN
    logic [NUM_SENSORS-1:0] clean_d;
    logic [NUM_SENSORS-1:0] sticky_q;

    // Remember rising Clean edges until consumed by an evaluation; a rise in
    // the EVAL cycle survives the clear so the next evaluation still sees it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clean_d  <= '0;
            sticky_q <= '0;
        end else begin
            clean_d  <= Clean;
            sticky_q <= (sticky_q & ~{NUM_SENSORS{state_q == S_EVAL}}) | (Clean & ~clean_d);
        end
    end

    assign eval_vec = Clean | sticky_q;
`else
    assign eval_vec = Clean;
`endif

    // Rule table: reset to defaults, writes outside the table are dropped.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                rules[IDX_W'(i)] <= {default_mode(i), NUM_SENSORS'(default_mask(i))};
            end
        end else if (RuleWe && (32'(RuleAddr) < NUM_RULES)) begin
            rules[IDX_W'(RuleAddr)] <= RuleData;
        end
    end

    // Rule lookup and evaluation for the latched selector.
    always_comb begin
        sel_legal = (32'(sel_q) < NUM_RULES);
        rule_cur  = rules[IDX_W'(sel_q)];
        rule_hit  = eval_rule(rule_mode_t'(rule_cur[RULE_W-1 -: MODE_W]),
                              MAX_SENSORS'(eval_vec),
                              MAX_SENSORS'(rule_cur[NUM_SENSORS-1:0]));
    end

    // Request FSM: next state and registered-output values.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        selerr_d  = selerr_q;
        valid_d   = 1'b0;
        latch_sel = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    state_d   = S_EVAL;
                    latch_sel = 1'b1;
                end
            end
            S_EVAL: begin
                state_d = S_DONE;
                valid_d = 1'b1;
                if (sel_legal) begin
                    y_d      = rule_hit;
                    selerr_d = 1'b0;
                end else begin
                    y_d      = 1'b0;
                    selerr_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!Enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            y_q      <= 1'b0;
            valid_q  <= 1'b0;
            selerr_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            selerr_q <= selerr_d;
            busy_q   <= busy_d;
            if (latch_sel) sel_q <= Selector;
        end
    end

    assign Y      = y_q;
    assign Valid  = valid_q;
    assign SelErr = selerr_q;
    assign Busy   = busy_q;

endmodule
